// File: rtl/branch_target_buffer_if.sv
// Signal bundle between the fetch/decode/execute pipeline and the branch
// target buffer. The pipeline side is the master: it presents PCs, pipeline
// control and resolved branch outcomes. The predictor side is the slave: it
// returns the prediction, the EX-stage prediction bit and the statistics.
interface branch_target_buffer_if;
   // fetch-stage lookup
   logic [31:0] PCF;
   logic        PredictedF;
   logic [31:0] PredictedPC;

   // pipeline-register control for the ID and EX stages
   logic        StallD;
   logic        FlushD;
   logic        StallE;
   logic        FlushE;

   // execute-stage resolution and training
   logic        PredictedE;
   logic [31:0] PCE;
   logic        IsBranchE;
   logic        BranchE;
   logic [31:0] BranchTarget;

   // statistics
   logic [31:0] BranchCount;
   logic [31:0] MissCount;

   modport master (
      output PCF,
      output StallD, FlushD, StallE, FlushE,
      output PCE, IsBranchE, BranchE, BranchTarget,
      input  PredictedF, PredictedPC, PredictedE,
      input  BranchCount, MissCount
   );

   modport slave (
      input  PCF,
      input  StallD, FlushD, StallE, FlushE,
      input  PCE, IsBranchE, BranchE, BranchTarget,
      output PredictedF, PredictedPC, PredictedE,
      output BranchCount, MissCount
   );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Lookup is purely combinational from the fetch PC so the NPC generator can
// use the prediction in the same cycle. The prediction bit is carried through
// the ID and EX pipeline registers so a misprediction can be detected in EX,
// where resolved conditional branches also train the table.
module branch_target_buffer #(
   parameter int INDEX_W = 6,
   parameter int TAG_W   = 30 - INDEX_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   branch_target_buffer_if.slave bus
);

   localparam int ENTRIES = 1 << INDEX_W;

   localparam logic [1:0] CNT_MAX    = 2'b11;
   localparam logic [1:0] CNT_MIN    = 2'b00;
   localparam logic [1:0] CNT_WEAK_T = 2'b10;

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------
   logic [ENTRIES-1:0] r_valid;
   logic [TAG_W-1:0]   r_tag    [ENTRIES];
   logic [29:0]        r_target [ENTRIES];
   logic [1:0]         r_cnt    [ENTRIES];

   // prediction bit travelling alongside the instruction in ID and EX
   logic               r_pred_d;
   logic               r_pred_e;

   logic [31:0]        r_branch_count;
   logic [31:0]        r_miss_count;

   // ------------------------------------------------------------------
   // Fetch-stage lookup
   // ------------------------------------------------------------------
   logic [INDEX_W-1:0] w_f_idx;
   logic [TAG_W-1:0]   w_f_tag;
   logic               w_f_hit;
   logic               w_pred_f;

   assign w_f_idx  = bus.PCF[INDEX_W+1:2];
   assign w_f_tag  = bus.PCF[INDEX_W+2 +: TAG_W];
   assign w_f_hit  = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
   // upper counter bit set means weakly or strongly taken
   assign w_pred_f = w_f_hit && r_cnt[w_f_idx][1];

   assign bus.PredictedF  = w_pred_f;
   assign bus.PredictedPC = w_pred_f ? {r_target[w_f_idx], 2'b00} : 32'h0000_0000;

   // ------------------------------------------------------------------
   // Execute-stage training
   // ------------------------------------------------------------------
   logic [INDEX_W-1:0] w_e_idx;
   logic [TAG_W-1:0]   w_e_tag;
   logic               w_e_hit;
   logic               w_upd;
   logic               w_mispredict;
   logic [1:0]         w_cnt_next;

   assign w_e_idx = bus.PCE[INDEX_W+1:2];
   assign w_e_tag = bus.PCE[INDEX_W+2 +: TAG_W];
   assign w_e_hit = r_valid[w_e_idx] && (r_tag[w_e_idx] == w_e_tag);

   // a stalled branch trains only in the cycle it finally leaves EX
   assign w_upd        = bus.IsBranchE && !bus.StallE;
   assign w_mispredict = bus.BranchE ^ r_pred_e;

   // saturating step of the hit entry's counter toward the resolved outcome
   always_comb begin
      // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
      w_cnt_next = r_cnt[w_e_idx];
      if (bus.BranchE) begin
         if (r_cnt[w_e_idx] != CNT_MAX) w_cnt_next = r_cnt[w_e_idx] + 2'd1;
      end else begin
         if (r_cnt[w_e_idx] != CNT_MIN) w_cnt_next = r_cnt[w_e_idx] - 2'd1;
      end
   end

   // valid bits: set on a taken-branch allocation, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         r_valid <= '0;
      end else if (w_upd && bus.BranchE) begin
         r_valid[w_e_idx] <= 1'b1;
      end
   end

   // entry payload: counter/target update on a hit, replacement on a taken miss
   always_ff @(posedge clk) begin
      // NOTE: the payload array has no reset; a cleared valid bit masks whatever it holds.
      if (w_upd) begin
         if (w_e_hit) begin
            r_cnt[w_e_idx] <= w_cnt_next;
            if (bus.BranchE) r_target[w_e_idx] <= bus.BranchTarget[31:2];
         end else if (bus.BranchE) begin
            r_tag[w_e_idx]    <= w_e_tag;
            r_target[w_e_idx] <= bus.BranchTarget[31:2];
            r_cnt[w_e_idx]    <= CNT_WEAK_T;
         end
      end
   end

   // ------------------------------------------------------------------
   // Prediction pipeline (flush wins over stall)
   // ------------------------------------------------------------------
   // carry the fetch prediction through the ID and EX pipeline registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pred_d <= 1'b0;
         r_pred_e <= 1'b0;
      end else begin
         if (bus.FlushD)      r_pred_d <= 1'b0;
         else if (!bus.StallD) r_pred_d <= w_pred_f;

         if (bus.FlushE)      r_pred_e <= 1'b0;
         else if (!bus.StallE) r_pred_e <= r_pred_d;
      end
   end

   assign bus.PredictedE = r_pred_e;

   // ------------------------------------------------------------------
   // Statistics (both wrap naturally at 2^32)
   // ------------------------------------------------------------------
   // count trained branches and those whose outcome disagreed with the prediction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_branch_count <= 32'd0;
         r_miss_count   <= 32'd0;
      end else if (w_upd) begin
         r_branch_count <= r_branch_count + 32'd1;
         if (w_mispredict) r_miss_count <= r_miss_count + 32'd1;
      end
   end

   assign bus.BranchCount = r_branch_count;
   assign bus.MissCount   = r_miss_count;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: a table-level model of the
// predictor is compared against the design on every falling clock edge, and
// directed scenarios add literal expectations at the interesting points.
module tb_branch_target_buffer;

   localparam int NENT = 64;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   branch_target_buffer_if bus ();

   branch_target_buffer #(.INDEX_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ------------------------------------------------------------------
   // Behavioural model: table of entries addressed by (pc/4) mod 64
   // ------------------------------------------------------------------
   typedef struct {
      bit          valid;
      int unsigned tag;
      int unsigned target;
      int          cnt;
   } ent_t;

   ent_t        m_btb [NENT];
   bit          m_pred_d = 0;
   bit          m_pred_e = 0;
   int unsigned m_bc = 0;
   int unsigned m_mc = 0;

   function automatic int unsigned m_idx(input logic [31:0] pc);
      return (pc / 4) % NENT;
   endfunction

   function automatic int unsigned m_tag(input logic [31:0] pc);
      return pc / (4 * NENT);
   endfunction

   function automatic bit m_pf(input logic [31:0] pc);
      int unsigned i;
      i = m_idx(pc);
      return m_btb[i].valid && (m_btb[i].tag == m_tag(pc)) && (m_btb[i].cnt >= 2);
   endfunction

   function automatic logic [31:0] m_ppc(input logic [31:0] pc);
      return m_pf(pc) ? m_btb[m_idx(pc)].target : 32'h0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      bit          pf, old_d, old_e;
      int unsigned i;
      if (!rst_n) begin
         for (int k = 0; k < NENT; k++) m_btb[k].valid = 0;
         m_pred_d = 0;
         m_pred_e = 0;
         m_bc     = 0;
         m_mc     = 0;
      end else begin
         pf    = m_pf(bus.PCF);
         old_d = m_pred_d;
         old_e = m_pred_e;
         if (bus.IsBranchE && !bus.StallE) begin
            m_bc++;
            if (bus.BranchE != old_e) m_mc++;
            i = m_idx(bus.PCE);
            if (m_btb[i].valid && m_btb[i].tag == m_tag(bus.PCE)) begin
               if (bus.BranchE) begin
                  m_btb[i].cnt    = (m_btb[i].cnt == 3) ? 3 : m_btb[i].cnt + 1;
                  m_btb[i].target = bus.BranchTarget & 32'hFFFF_FFFC;
               end else begin
                  m_btb[i].cnt = (m_btb[i].cnt == 0) ? 0 : m_btb[i].cnt - 1;
               end
            end else if (bus.BranchE) begin
               m_btb[i].valid  = 1;
               m_btb[i].tag    = m_tag(bus.PCE);
               m_btb[i].target = bus.BranchTarget & 32'hFFFF_FFFC;
               m_btb[i].cnt    = 2;
            end
         end
         if (bus.FlushD)      m_pred_d = 0;
         else if (!bus.StallD) m_pred_d = pf;
         if (bus.FlushE)      m_pred_e = 0;
         else if (!bus.StallE) m_pred_e = old_d;
      end
   end

   // ------------------------------------------------------------------
   // Checking
   // ------------------------------------------------------------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("model PredictedF",  {31'b0, bus.PredictedF}, {31'b0, m_pf(bus.PCF)});
      check("model PredictedPC", bus.PredictedPC, m_ppc(bus.PCF));
      check("model PredictedE",  {31'b0, bus.PredictedE}, {31'b0, m_pred_e});
      check("model BranchCount", bus.BranchCount, m_bc);
      check("model MissCount",   bus.MissCount, m_mc);
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] pcf, input logic [31:0] pce,
                        input bit isb, input bit br, input logic [31:0] tgt);
      bus.PCF          = pcf;
      bus.PCE          = pce;
      bus.IsBranchE    = isb;
      bus.BranchE      = br;
      bus.BranchTarget = tgt;
   endtask

   task automatic ctrl(input bit sd, input bit fd, input bit se, input bit fe);
      bus.StallD = sd;
      bus.FlushD = fd;
      bus.StallE = se;
      bus.FlushE = fe;
   endtask

   task automatic look(input logic [31:0] pcf);
      bus.PCF = pcf;
      #1;
   endtask

   task automatic drain();
      drive(32'h0, 32'h0, 0, 0, 32'h0);
      repeat (2) tick();
   endtask

   int unsigned bc0;

   initial begin
      rst_n = 1'b0;
      ctrl(0, 0, 0, 0);
      drive(32'h0, 32'h0, 0, 0, 32'h0);

      // reset state
      tick();
      tick();
      look(32'h10);
      check("reset PredictedF", {31'b0, bus.PredictedF}, 32'd0);
      check("reset PredictedPC", bus.PredictedPC, 32'h0);
      check("reset PredictedE", {31'b0, bus.PredictedE}, 32'd0);
      check("reset BranchCount", bus.BranchCount, 32'd0);
      rst_n = 1'b1;
      drive(32'h0, 32'h0, 0, 0, 32'h0);
      tick();

      // allocate taken branch at 0x10 -> target 0x40, predicted not-taken
      drive(32'h0, 32'h10, 1, 1, 32'h40);
      tick();
      drive(32'h10, 32'h0, 0, 0, 32'h0);
      #1;
      check("alloc PredictedF", {31'b0, bus.PredictedF}, 32'd1);
      check("alloc PredictedPC", bus.PredictedPC, 32'h40);
      check("alloc BranchCount", bus.BranchCount, 32'd1);
      check("alloc MissCount", bus.MissCount, 32'd1);
      drain();

      // hysteresis: 2 -> 1 (not taken)
      drive(32'h0, 32'h10, 1, 0, 32'h0);
      tick();
      look(32'h10);
      check("hyst cnt1 PredictedF", {31'b0, bus.PredictedF}, 32'd0);
      // 1 -> 2 -> 3 -> 3 (three taken), then 3 -> 2
      drive(32'h0, 32'h10, 1, 1, 32'h40);
      repeat (3) tick();
      drive(32'h0, 32'h10, 1, 0, 32'h0);
      tick();
      look(32'h10);
      check("hyst sat-high PredictedF", {31'b0, bus.PredictedF}, 32'd1);
      check("hyst sat-high PredictedPC", bus.PredictedPC, 32'h40);
      // 2 -> 1 -> 0 -> 0 -> 0, then taken -> 1 (still not predicted)
      bus.PCF = 32'h0;
      repeat (4) tick();
      drive(32'h0, 32'h10, 1, 1, 32'h40);
      tick();
      look(32'h10);
      check("hyst sat-low PredictedF", {31'b0, bus.PredictedF}, 32'd0);
      bus.PCF = 32'h0;
      tick();
      look(32'h10);
      check("hyst recover PredictedF", {31'b0, bus.PredictedF}, 32'd1);
      drain();

      // aliasing: 0x110 shares index 4 with 0x10 but has tag 1
      look(32'h110);
      check("alias lookup PredictedF", {31'b0, bus.PredictedF}, 32'd0);
      drive(32'h0, 32'h110, 1, 1, 32'h80);
      tick();
      drive(32'h0, 32'h0, 0, 0, 32'h0);
      look(32'h10);
      check("alias evicted PredictedF", {31'b0, bus.PredictedF}, 32'd0);
      look(32'h110);
      check("alias new PredictedF", {31'b0, bus.PredictedF}, 32'd1);
      check("alias new PredictedPC", bus.PredictedPC, 32'h80);

      // non-branch aliasing a valid entry never writes
      drive(32'h110, 32'h10, 0, 1, 32'h99);
      tick();
      look(32'h110);
      check("nonbranch PredictedPC", bus.PredictedPC, 32'h80);

      // not-taken miss allocates nothing
      drive(32'h0, 32'h20, 1, 0, 32'h400);
      tick();
      drive(32'h0, 32'h0, 0, 0, 32'h0);
      look(32'h20);
      check("nt-miss PredictedF", {31'b0, bus.PredictedF}, 32'd0);

      // pipeline control: clear both stages, then stall ID for 2 cycles
      ctrl(0, 1, 0, 1);
      tick();
      ctrl(1, 0, 0, 0);
      bus.PCF = 32'h110;
      repeat (2) tick();
      check("stallD held PredictedE", {31'b0, bus.PredictedE}, 32'd0);
      ctrl(0, 0, 0, 0);
      tick();
      check("stallD +1 PredictedE", {31'b0, bus.PredictedE}, 32'd0);
      tick();
      check("stallD +2 PredictedE", {31'b0, bus.PredictedE}, 32'd1);
      ctrl(0, 0, 0, 1);
      tick();
      check("flushE PredictedE", {31'b0, bus.PredictedE}, 32'd0);
      ctrl(0, 0, 0, 0);
      tick();
      check("post-flush PredictedE", {31'b0, bus.PredictedE}, 32'd1);
      drain();

      // branch held in EX for 3 stalled cycles trains once
      bc0 = m_bc;
      drive(32'h0, 32'h30, 1, 1, 32'h100);
      ctrl(0, 0, 1, 0);
      repeat (3) tick();
      look(32'h30);
      check("stallE no-train PredictedF", {31'b0, bus.PredictedF}, 32'd0);
      check("stallE no-count", bus.BranchCount, bc0);
      bus.PCF = 32'h0;
      ctrl(0, 0, 0, 0);
      tick();
      drive(32'h0, 32'h0, 0, 0, 32'h0);
      look(32'h30);
      check("stallE trained PredictedPC", bus.PredictedPC, 32'h100);
      check("stallE count+1", bus.BranchCount, bc0 + 1);

      // same-cycle lookup and update of index 4 (currently tag 1)
      drive(32'h10, 32'h10, 1, 1, 32'hC0);
      #1;
      check("same-cycle old PredictedF", {31'b0, bus.PredictedF}, 32'd0);
      tick();
      drive(32'h10, 32'h0, 0, 0, 32'h0);
      #1;
      check("same-cycle new PredictedF", {31'b0, bus.PredictedF}, 32'd1);
      check("same-cycle new PredictedPC", bus.PredictedPC, 32'hC0);
      tick();

      // asynchronous reset in the middle of an update
      drive(32'h10, 32'h30, 1, 0, 32'h0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset PredictedF", {31'b0, bus.PredictedF}, 32'd0);
      check("midreset PredictedE", {31'b0, bus.PredictedE}, 32'd0);
      check("midreset BranchCount", bus.BranchCount, 32'd0);
      check("midreset MissCount", bus.MissCount, 32'd0);
      repeat (2) tick();
      drive(32'h0, 32'h0, 0, 0, 32'h0);
      rst_n = 1'b1;
      for (int t = 0; t < 2; t++) begin
         for (int k = 0; k < NENT; k++) begin
            look(32'(t * 256 + k * 4));
            check("post-reset sweep PredictedF", {31'b0, bus.PredictedF}, 32'd0);
         end
      end
      check("post-reset BranchCount", bus.BranchCount, 32'd0);
      check("post-reset MissCount", bus.MissCount, 32'd0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
